fp_apu_cmp_responder: RTL

Responder side of the APU handshake (`apu_req`/`apu_gnt`/`apu_rvalid`) for single-precision non-arithmetic FP operations: FMV.X.W, FMIN, FMAX and FCLASS. It sits behind the core's APU request port, next to the FP wrapper. It accepts one request per cycle and returns every result in order after a fixed, parameterised pipeline latency.

---
 rtl/fp_apu_cmp_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_apu_cmp_responder.sv
// APU responder for single-precision FMV.X.W, FMIN, FMAX and FCLASS.
// Fixed-latency in-order pipeline; grant held high after reset, no backpressure.
module fp_apu_cmp_responder #(
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        apu_req_i,
    output logic        apu_gnt_o,
    input  logic [95:0] apu_operands_i,
    input  logic [4:0]  apu_op_i,
    input  logic [9:0]  apu_flags_i,
    output logic        apu_rvalid_o,
    output logic [31:0] apu_rdata_o,
    output logic [3:0]  apu_rflags_o
);

    localparam logic [4:0] OP_FMV    = 5'b01100;
    localparam logic [4:0] OP_FMIN   = 5'b01101;
    localparam logic [4:0] OP_FMAX   = 5'b01110;
    localparam logic [4:0] OP_FCLASS = 5'b01111;
    localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;
    localparam logic [3:0]  FLAG_NV   = 4'b1000;

    logic        pipe_valid [1:LATENCY];
    logic [4:0]  pipe_op    [1:LATENCY];
    logic [31:0] pipe_a     [1:LATENCY];
    logic [31:0] pipe_b     [1:LATENCY];

    logic        accept;
    logic [4:0]  op_in;
    logic        unused_bits;

    assign accept      = apu_req_i && apu_gnt_o;
    // Double-precision requests are folded onto an unsupported opcode at capture.
    assign op_in       = apu_flags_i[0] ? apu_op_i : 5'b00000;
    assign unused_bits = ^{apu_operands_i[95:64], apu_flags_i[9:1]};

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    // Total order with -0 below +0; caller excludes NaNs.
    function automatic logic less_than(input logic [31:0] x, input logic [31:0] y);
        if (x[31] != y[31])
            return x[31];
        else if (x[31])
            return x[30:0] > y[30:0];
        else
            return x[30:0] < y[30:0];
    endfunction

    function automatic logic [9:0] classify(input logic [31:0] x);
        logic [9:0] c;
        c = '0;
        if (x[30:23] == 8'hff) begin
            if (x[22:0] == 23'd0)
                c[x[31] ? 0 : 7] = 1'b1;
            else if (x[22])
                c[9] = 1'b1;
            else
                c[8] = 1'b1;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0)
                c[x[31] ? 3 : 4] = 1'b1;
            else
                c[x[31] ? 2 : 5] = 1'b1;
        end else begin
            c[x[31] ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            apu_gnt_o <= 1'b0;
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_op[i]    <= '0;
                pipe_a[i]     <= '0;
                pipe_b[i]     <= '0;
            end
        end else begin
            apu_gnt_o     <= 1'b1;
            pipe_valid[1] <= accept;
            if (accept) begin
                pipe_op[1] <= op_in;
                pipe_a[1]  <= apu_operands_i[31:0];
                pipe_b[1]  <= apu_operands_i[63:32];
            end
            for (int i = 2; i <= LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_op[i]    <= pipe_op[i-1];
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
            end
        end
    end

    logic [31:0] fa, fb;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        a_lt_b;

    assign fa     = pipe_a[LATENCY];
    assign fb     = pipe_b[LATENCY];
    assign a_lt_b = less_than(fa, fb);

    always_comb begin
        res_data  = '0;
        res_flags = '0;
        case (pipe_op[LATENCY])
            OP_FMV: res_data = fa;
            OP_FMIN, OP_FMAX: begin
                if (is_nan(fa) && is_nan(fb))
                    res_data = CANON_NAN;
                else if (is_nan(fa))
                    res_data = fb;
                else if (is_nan(fb))
                    res_data = fa;
                else if (pipe_op[LATENCY] == OP_FMIN)
                    res_data = a_lt_b ? fa : fb;
                else
                    res_data = a_lt_b ? fb : fa;
                if (is_snan(fa) || is_snan(fb))
                    res_flags = FLAG_NV;
            end
            OP_FCLASS: res_data = {22'd0, classify(fa)};
            default:   res_flags = FLAG_NV;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            apu_rvalid_o <= 1'b0;
            apu_rdata_o  <= '0;
            apu_rflags_o <= '0;
        end else begin
            apu_rvalid_o <= pipe_valid[LATENCY];
            if (pipe_valid[LATENCY]) begin
                apu_rdata_o  <= res_data;
                apu_rflags_o <= res_flags;
            end
        end
    end

endmodule
